image_buffer: RTL and testbench

- Upstream stage of the softmax inference core.
- Assembles 784-byte preprocessed signed pixel frames from the UART byte stream into a ping-pong image RAM.
- Serves the inference core's pixel read port from the completed bank while the next frame fills the other bank.
- Issues the start_inference pulse and tracks inference ownership of the read bank.

---
 rtl/image_buffer.sv | 135 +++++++++++++
 tb/tb_image_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_buffer.sv
`default_nettype none
// image_buffer: assembles UART pixel bytes into a ping-pong frame RAM and
// hands each completed frame to the inference core.
module image_buffer #(
  parameter int NUM_PIXELS     = 784,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        weights_ready,
  input  logic        infer_busy,
  input  logic        infer_done,
  input  logic [9:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        start_inference,
  output logic        frame_error,
  output logic        overrun,
  output logic [15:0] drop_count,
  output logic [7:0]  frame_count
);

  localparam int                IDLE_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]        PIX_LAST  = 10'(NUM_PIXELS - 1);
  localparam logic [9:0]        PIX_NUM   = 10'(NUM_PIXELS);

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_FILL = 2'd1,
    RX_FULL = 2'd2
  } rx_state_t;

  rx_state_t         state, state_nx;
  logic [9:0]        count, count_nx;
  logic [IDLE_W-1:0] idle_cnt, idle_nx;
  logic              wr_bank, rd_bank, lock;
  logic              wr_en, swap, timeout, drop;

  logic [7:0] bank0 [NUM_PIXELS];
  logic [7:0] bank1 [NUM_PIXELS];

  always_comb begin
    state_nx = state;
    count_nx = count;
    idle_nx  = idle_cnt;
    wr_en    = 1'b0;
    swap     = 1'b0;
    timeout  = 1'b0;
    drop     = 1'b0;
    case (state)
      RX_IDLE, RX_FILL: begin
        // count is 0 in RX_IDLE, so both states write at index count
        if (rx_valid) begin
          wr_en   = 1'b1;
          idle_nx = '0;
          if (count == PIX_LAST) begin
            count_nx = '0;
            state_nx = RX_FULL;
          end else begin
            count_nx = count + 10'd1;
            state_nx = RX_FILL;
          end
        end else if (state == RX_FILL) begin
          if (idle_cnt == IDLE_LAST) begin
            count_nx = '0;
            idle_nx  = '0;
            timeout  = 1'b1;
            state_nx = RX_IDLE;
          end else begin
            idle_nx = idle_cnt + IDLE_W'(1);
          end
        end
      end
      RX_FULL: begin
        drop = rx_valid;
        if (!lock && weights_ready && !infer_busy) begin
          swap     = 1'b1;
          state_nx = RX_IDLE;
        end
      end
      default: state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RX_IDLE;
      count           <= '0;
      idle_cnt        <= '0;
      wr_bank         <= 1'b0;
      rd_bank         <= 1'b1;
      lock            <= 1'b0;
      start_inference <= 1'b0;
      frame_error     <= 1'b0;
      overrun         <= 1'b0;
      drop_count      <= '0;
      frame_count     <= '0;
    end else begin
      state           <= state_nx;
      count           <= count_nx;
      idle_cnt        <= idle_nx;
      start_inference <= swap;
      frame_error     <= timeout;
      // lock blocks the swap, so swap and infer_done never coincide
      if (swap) begin
        rd_bank     <= wr_bank;
        wr_bank     <= ~wr_bank;
        lock        <= 1'b1;
        frame_count <= frame_count + 8'd1;
      end else if (infer_done) begin
        lock <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst && !wr_bank) bank0[count] <= rx_data;
    if (wr_en && !rst &&  wr_bank) bank1[count] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst)                   rd_data <= '0;
    else if (rd_addr >= PIX_NUM) rd_data <= '0;
    else if (rd_bank)          rd_data <= bank1[rd_addr];
    else                       rd_data <= bank0[rd_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_image_buffer.sv
`default_nettype none
// tb_image_buffer: randomized frame traffic against a frame-level model;
// expected pulses and read data are queued and checked by a monitor.
module tb_image_buffer;
  localparam int NP = 784;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        weights_ready;
  logic        infer_busy;
  logic        infer_done;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        start_inference;
  logic        frame_error;
  logic        overrun;
  logic [15:0] drop_count;
  logic [7:0]  frame_count;

  image_buffer #(.NUM_PIXELS(NP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .weights_ready(weights_ready), .infer_busy(infer_busy), .infer_done(infer_done),
    .rd_addr(rd_addr), .rd_data(rd_data), .start_inference(start_inference),
    .frame_error(frame_error), .overrun(overrun), .drop_count(drop_count),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int at; int val; } exp_t;
  exp_t start_q[$];
  exp_t err_q[$];
  exp_t rd_q[$];

  logic [7:0] frm    [NP];
  logic [7:0] exp_rd [NP];
  int dispatched = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every DUT pulse or read response is matched against the queues.
  always @(negedge clk) begin
    exp_t e;
    if (start_inference !== 1'b0) begin
      if (start_q.size() == 0) chk("start_unexpected", {31'd0, start_inference}, 32'd0);
      else begin
        e = start_q.pop_front();
        chk("start_cycle", cyc, e.at);
        chk("start_frame_count", {24'd0, frame_count}, e.val);
      end
    end
    if (frame_error !== 1'b0) begin
      if (err_q.size() == 0) chk("frame_error_unexpected", {31'd0, frame_error}, 32'd0);
      else begin
        e = err_q.pop_front();
        chk("frame_error_cycle", cyc, e.at);
      end
    end
    if (rd_q.size() > 0 && rd_q[0].at <= cyc) begin
      e = rd_q.pop_front();
      chk("rd_cycle", cyc, e.at);
      chk("rd_data", {24'd0, rd_data}, e.val);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_start(input int at);
    dispatched = dispatched + 1;
    start_q.push_back('{at: at, val: dispatched % 256});
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    step(gap);
  endtask

  // Streams frm; a dispatch is expected two cycles after the last byte when free.
  task automatic send_frame(input int gmin, input int gmax, input bit dispatch);
    for (int i = 0; i < NP; i++) begin
      rx_data  = frm[i];
      rx_valid = 1'b1;
      if (i == NP - 1 && dispatch) begin
        expect_start(cyc + 2);
        exp_rd = frm;
      end
      step();
      rx_valid = 1'b0;
      step(int'($urandom_range(gmax, gmin)));
    end
  endtask

  task automatic rd_check(input int a);
    int v;
    v = (a < NP) ? int'(exp_rd[a]) : 0;
    rd_addr = 10'(a);
    rd_q.push_back('{at: cyc + 1, val: v});
    step();
  endtask

  task automatic settle(input int n);
    step(n);
    chk("start_pending", start_q.size(), 32'd0);
    chk("frame_error_pending", err_q.size(), 32'd0);
    chk("rd_pending", rd_q.size(), 32'd0);
  endtask

  task automatic check_zero();
    chk("zero_rd_data", {24'd0, rd_data}, 32'd0);
    chk("zero_start", {31'd0, start_inference}, 32'd0);
    chk("zero_frame_error", {31'd0, frame_error}, 32'd0);
    chk("zero_overrun", {31'd0, overrun}, 32'd0);
    chk("zero_drop_count", {16'd0, drop_count}, 32'd0);
    chk("zero_frame_count", {24'd0, frame_count}, 32'd0);
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < NP; i++) frm[i] = 8'($urandom);
  endtask

  task automatic release_lock(input bit dispatch);
    infer_done = 1'b1;
    infer_busy = 1'b0;
    if (dispatch) begin
      expect_start(cyc + 2);
      exp_rd = frm;
    end
    step();
    infer_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; weights_ready = 1'b1;
    infer_busy = 1'b0; infer_done = 1'b0; rd_addr = '0;
    step(3);
    check_zero();
    rst = 1'b0;
    step(2);

    // Ramp frame, one byte per 10 clocks
    for (int i = 0; i < NP; i++) frm[i] = 8'(i);
    send_frame(9, 9, 1'b1);
    settle(5);
    rd_check(5);
    rd_check(783);
    rd_check(900);
    settle(3);

    // Second frame waits while the core is busy and the bank is locked
    infer_busy = 1'b1;
    for (int i = 0; i < NP; i++) frm[i] = 8'h80;
    send_frame(0, 3, 1'b0);
    settle(20);
    release_lock(1'b1);
    settle(5);
    rd_check(0);
    rd_check(int'($urandom_range(NP - 1, 0)));
    settle(3);

    // Buffered frame plus a full frame of dropped bytes
    randomize_frame();
    send_frame(0, 3, 1'b0);
    chk("overrun_before_drop", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < NP; i++) send_byte(8'($urandom), int'($urandom_range(2, 0)));
    settle(5);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    chk("drop_count", {16'd0, drop_count}, NP);
    release_lock(1'b1);
    settle(5);
    rd_check(0);
    rd_check(NP - 1);
    for (int k = 0; k < 6; k++) rd_check(int'($urandom_range(NP - 1, 0)));
    settle(3);

    // Partial frame times out, then a fresh frame is dispatched
    release_lock(1'b0);
    settle(5);
    for (int i = 0; i < 100; i++) begin
      rx_data  = 8'($urandom);
      rx_valid = 1'b1;
      // counter clears on the last byte; TO idle clocks then the discard edge
      if (i == 99) err_q.push_back('{at: cyc + TO + 1, val: 0});
      step();
      rx_valid = 1'b0;
      if (i < 99) step(int'($urandom_range(3, 0)));
    end
    settle(TO + 10);
    randomize_frame();
    send_frame(0, 3, 1'b1);
    settle(5);
    rd_check(0);
    rd_check(int'($urandom_range(NP - 1, 0)));
    settle(3);

    // Frame parked until weights are loaded
    release_lock(1'b0);
    settle(5);
    weights_ready = 1'b0;
    randomize_frame();
    send_frame(0, 3, 1'b0);
    settle(1000);
    weights_ready = 1'b1;
    // already in the full state, so the swap happens on this edge
    expect_start(cyc + 1);
    exp_rd = frm;
    step();
    settle(5);
    rd_check(0);
    rd_check(int'($urandom_range(NP - 1, 0)));
    settle(3);

    // Reset mid-frame discards the partial frame silently
    release_lock(1'b0);
    settle(5);
    randomize_frame();
    for (int i = 0; i < 400; i++) send_byte(frm[i], int'($urandom_range(3, 0)));
    rst = 1'b1;
    step();
    check_zero();
    rst = 1'b0;
    dispatched = 0;
    step(2);
    randomize_frame();
    send_frame(0, 3, 1'b1);
    settle(5);
    chk("frame_count_after_reset", {24'd0, frame_count}, 32'd1);
    rd_check(0);
    rd_check(NP - 1);
    rd_check(int'($urandom_range(NP - 1, 0)));
    settle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
